// File: rtl/dht_fmt_pkg.sv
// rtl/dht_fmt_pkg.sv - shared ASCII constants, FSM state type and line layout for the DHT formatter
package dht_fmt_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_X     = 8'h58;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int POS_W = 5;

  localparam logic [POS_W-1:0] POS_ID    = 5'd0;
  localparam logic [POS_W-1:0] POS_T10   = 5'd8;
  localparam logic [POS_W-1:0] POS_T0    = 5'd9;
  localparam logic [POS_W-1:0] POS_TDOT  = 5'd10;
  localparam logic [POS_W-1:0] POS_TMIN  = 5'd11;
  localparam logic [POS_W-1:0] POS_H10   = 5'd19;
  localparam logic [POS_W-1:0] POS_H0    = 5'd20;
  localparam logic [POS_W-1:0] POS_HDOT  = 5'd21;
  localparam logic [POS_W-1:0] POS_HMIN  = 5'd22;
  localparam logic [POS_W-1:0] POS_TAB   = 5'd23;
  localparam logic [POS_W-1:0] POS_STAT0 = 5'd24;
  localparam logic [POS_W-1:0] POS_STAT1 = 5'd25;
  localparam logic [POS_W-1:0] POS_EOL0  = 5'd26;
  localparam logic [POS_W-1:0] POS_EOL1  = 5'd27;

  function automatic int LINE_LEN(input bit eol_crlf);
    return eol_crlf ? 28 : 27;
  endfunction

endpackage

// File: rtl/dht_line_rom.sv
// rtl/dht_line_rom.sv - combinational character lookup for one position of a sensor line
module dht_line_rom
  import dht_fmt_pkg::*;
#(
  parameter bit LZ_SUPPRESS = 1'b1,
  parameter bit EOL_CRLF    = 1'b1
) (
  input  logic [POS_W-1:0] pos,
  input  logic [1:0]       ch,
  input  logic [3:0]       t10,
  input  logic [3:0]       t0,
  input  logic [3:0]       tmin,
  input  logic [3:0]       h10,
  input  logic [3:0]       h0,
  input  logic [3:0]       hmin,
  input  logic             err,
  output logic [7:0]       ascii
);

  function automatic logic [7:0] bcd_ascii(input logic [3:0] v, input bit tens);
    if (tens && LZ_SUPPRESS && (v == 4'd0)) return ASCII_SPACE;
    if (v > 4'd9) return ASCII_QMARK;
    return ASCII_ZERO + {4'd0, v};
  endfunction

  always_comb begin
    ascii = ASCII_SPACE;
    case (pos)
      POS_ID:    ascii = ASCII_ZERO + {6'd0, ch};
      5'd2:      ascii = 8'h74;
      5'd3:      ascii = 8'h65;
      5'd4:      ascii = 8'h6D;
      5'd5:      ascii = 8'h70;
      5'd6:      ascii = ASCII_COLON;
      POS_T10:   ascii = bcd_ascii(t10, 1'b1);
      POS_T0:    ascii = bcd_ascii(t0, 1'b0);
      POS_TDOT:  ascii = ASCII_DOT;
      POS_TMIN:  ascii = bcd_ascii(tmin, 1'b0);
      5'd13:     ascii = 8'h68;
      5'd14:     ascii = 8'h75;
      5'd15:     ascii = 8'h6D;
      5'd16:     ascii = 8'h69;
      5'd17:     ascii = ASCII_COLON;
      POS_H10:   ascii = bcd_ascii(h10, 1'b1);
      POS_H0:    ascii = bcd_ascii(h0, 1'b0);
      POS_HDOT:  ascii = ASCII_DOT;
      POS_HMIN:  ascii = bcd_ascii(hmin, 1'b0);
      POS_TAB:   ascii = ASCII_TAB;
      POS_STAT0: ascii = err ? ASCII_X : 8'h4F;
      POS_STAT1: ascii = err ? ASCII_X : 8'h4B;
      POS_EOL0:  ascii = EOL_CRLF ? ASCII_CR : ASCII_LF;
      POS_EOL1:  ascii = ASCII_LF;
      default:   ascii = ASCII_SPACE;
    endcase
  end

endmodule

// File: rtl/dht_uart_formatter.sv
// rtl/dht_uart_formatter.sv - snapshots NUM_SENS sensor readings and streams one ASCII line per sensor
module dht_uart_formatter
  import dht_fmt_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SENS    = 2,
  parameter bit LZ_SUPPRESS = 1'b1,
  parameter bit EOL_CRLF    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [4*NUM_SENS-1:0] i_temp10,
  input  logic [4*NUM_SENS-1:0] i_temp0,
  input  logic [4*NUM_SENS-1:0] i_temp_min,
  input  logic [4*NUM_SENS-1:0] i_humi10,
  input  logic [4*NUM_SENS-1:0] i_humi0,
  input  logic [4*NUM_SENS-1:0] i_humi_min,
  input  logic [NUM_SENS-1:0]   i_error,
  output logic                  o_tx_valid,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overrun
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(LINE_LEN(EOL_CRLF) - 1);
  localparam logic [1:0]       LAST_CH  = 2'(NUM_SENS - 1);

  state_t                  state_q, state_d;
  logic [1:0]              ch_q, ch_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [4*NUM_SENS-1:0]   t10_q, t0_q, tmin_q, h10_q, h0_q, hmin_q;
  logic [NUM_SENS-1:0]     err_q;
  logic                    overrun_q;
  logic                    load;
  logic [7:0]              ascii;

  assign load = (state_q == ST_IDLE) && i_start;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pos_d   = pos_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SEND;
          ch_d    = 2'd0;
          pos_d   = '0;
        end
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          if (pos_q == LAST_POS) begin
            pos_d = '0;
            if (ch_q == LAST_CH) state_d = ST_DONE;
            else                 ch_d    = ch_q + 2'd1;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= 2'd0;
      pos_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      pos_q     <= pos_d;
      overrun_q <= i_start && (state_q != ST_IDLE);
    end
  end

  // Snapshot is taken only on an accepted start, so input changes mid-frame are invisible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t10_q  <= '0;
      t0_q   <= '0;
      tmin_q <= '0;
      h10_q  <= '0;
      h0_q   <= '0;
      hmin_q <= '0;
      err_q  <= '0;
    end else if (load) begin
      t10_q  <= i_temp10;
      t0_q   <= i_temp0;
      tmin_q <= i_temp_min;
      h10_q  <= i_humi10;
      h0_q   <= i_humi0;
      hmin_q <= i_humi_min;
      err_q  <= i_error;
    end
  end

  dht_line_rom #(
    .LZ_SUPPRESS (LZ_SUPPRESS),
    .EOL_CRLF    (EOL_CRLF)
  ) u_rom (
    .pos   (pos_q),
    .ch    (ch_q),
    .t10   (t10_q[4*ch_q +: 4]),
    .t0    (t0_q[4*ch_q +: 4]),
    .tmin  (tmin_q[4*ch_q +: 4]),
    .h10   (h10_q[4*ch_q +: 4]),
    .h0    (h0_q[4*ch_q +: 4]),
    .hmin  (hmin_q[4*ch_q +: 4]),
    .err   (err_q[ch_q]),
    .ascii (ascii)
  );

  assign o_tx_valid = (state_q == ST_SEND);
  assign o_tx_data  = o_tx_valid ? DATA_WIDTH'(ascii) : '0;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = (state_q == ST_DONE);
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_dht_uart_formatter.sv
// tb/tb_dht_uart_formatter.sv - scoreboard bench for dht_uart_formatter in two configurations
module tb_dht_uart_formatter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;
  logic ready;
  logic use_b;

  logic       a_start, a_valid, a_busy, a_done, a_overrun;
  logic [7:0] a_data;
  logic [7:0] a_t10, a_t0, a_tmin, a_h10, a_h0, a_hmin;
  logic [1:0] a_err;

  logic       b_start, b_valid, b_busy, b_done, b_overrun;
  logic [7:0] b_data;
  logic [3:0] b_t10, b_t0, b_tmin, b_h10, b_h0, b_hmin;
  logic [0:0] b_err;

  logic       m_valid, m_done, m_overrun;
  logic [7:0] m_data;

  assign a_start   = start && !use_b;
  assign b_start   = start && use_b;
  assign m_valid   = use_b ? b_valid   : a_valid;
  assign m_data    = use_b ? b_data    : a_data;
  assign m_done    = use_b ? b_done    : a_done;
  assign m_overrun = use_b ? b_overrun : a_overrun;

  dht_uart_formatter #(.DATA_WIDTH(8), .NUM_SENS(2), .LZ_SUPPRESS(1'b1), .EOL_CRLF(1'b1)) dut_a (
    .clk(clk), .rst(rst), .i_start(a_start),
    .i_temp10(a_t10), .i_temp0(a_t0), .i_temp_min(a_tmin),
    .i_humi10(a_h10), .i_humi0(a_h0), .i_humi_min(a_hmin), .i_error(a_err),
    .o_tx_valid(a_valid), .o_tx_data(a_data), .i_tx_ready(ready),
    .o_busy(a_busy), .o_done(a_done), .o_overrun(a_overrun)
  );

  dht_uart_formatter #(.DATA_WIDTH(8), .NUM_SENS(1), .LZ_SUPPRESS(1'b0), .EOL_CRLF(1'b0)) dut_b (
    .clk(clk), .rst(rst), .i_start(b_start),
    .i_temp10(b_t10), .i_temp0(b_t0), .i_temp_min(b_tmin),
    .i_humi10(b_h10), .i_humi0(b_h0), .i_humi_min(b_hmin), .i_error(b_err),
    .o_tx_valid(b_valid), .o_tx_data(b_data), .i_tx_ready(ready),
    .o_busy(b_busy), .o_done(b_done), .o_overrun(b_overrun)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] dig(input logic [3:0] v, input bit tens, input bit lz);
    if (tens && lz && v == 4'd0) return 8'h20;
    if (v > 4'd9) return 8'h3F;
    return 8'h30 + 8'(v);
  endfunction

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endfunction

  function automatic void push_line(input int ch, input logic [3:0] t10, t0, tm, h10, h0, hm,
                                    input bit err, input bit lz, input bit crlf);
    exp_q.push_back(8'(8'h30 + ch));
    push_str(" temp: ");
    exp_q.push_back(dig(t10, 1'b1, lz));
    exp_q.push_back(dig(t0, 1'b0, lz));
    push_str(".");
    exp_q.push_back(dig(tm, 1'b0, lz));
    push_str(" humi: ");
    exp_q.push_back(dig(h10, 1'b1, lz));
    exp_q.push_back(dig(h0, 1'b0, lz));
    push_str(".");
    exp_q.push_back(dig(hm, 1'b0, lz));
    exp_q.push_back(8'h09);
    push_str(err ? "XX" : "OK");
    if (crlf) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic void push_frame();
    if (use_b) begin
      push_line(0, b_t10, b_t0, b_tmin, b_h10, b_h0, b_hmin, b_err[0], 1'b0, 1'b0);
    end else begin
      for (int k = 0; k < 2; k++)
        push_line(k, a_t10[4*k +: 4], a_t0[4*k +: 4], a_tmin[4*k +: 4],
                  a_h10[4*k +: 4], a_h0[4*k +: 4], a_hmin[4*k +: 4], a_err[k], 1'b1, 1'b1);
    end
  endfunction

  // Runs one frame on the selected DUT, popping the scoreboard on every accepted byte.
  task automatic run_frame(input int stall_pct, input int ovr_at, input int chg_at,
                           input string tag, output int nbytes, output int novr, output int ncyc);
    logic [7:0] held, exp;
    bit stalled, last_acc, fin, ovr_done, chg_done;
    nbytes = 0; novr = 0; ncyc = 0;
    stalled = 0; last_acc = 0; fin = 0; ovr_done = 0; chg_done = 0; held = 8'h00;
    push_frame();
    @(posedge clk); #1;
    start = 1'b1;
    ready = ($urandom_range(99) >= stall_pct);
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && ncyc < 2000) begin
      @(negedge clk);
      ncyc++;
      if (m_overrun) novr++;
      if (stalled) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b data=%h required valid=1 data=%h", tag, m_valid, m_data, held);
        end
      end
      if (last_acc) begin
        checks++;
        if (m_done !== 1'b1 || m_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s done_timing: done=%b valid=%b required done=1 valid=0", tag, m_done, m_valid);
        end
        fin = 1;
      end else if (m_done === 1'b1) begin
        checks++; errors++;
        $display("FAIL %s early_done: done=1 after %0d bytes, required 0 until queue drained", tag, nbytes);
      end
      stalled = 0;
      if (!fin && m_valid === 1'b1 && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_byte: got %h, required no byte", tag, m_data);
        end else begin
          exp = exp_q.pop_front();
          if (m_data !== exp) begin
            errors++;
            $display("FAIL %s byte%0d: got %h required %h", tag, nbytes, m_data, exp);
          end
          if (exp_q.size() == 0) last_acc = 1;
        end
        nbytes++;
      end else if (!fin && m_valid === 1'b1) begin
        stalled = 1;
        held = m_data;
      end
      @(posedge clk); #1;
      ready = ($urandom_range(99) >= stall_pct);
      start = 1'b0;
      if (!ovr_done && ovr_at >= 0 && nbytes >= ovr_at) begin
        start = 1'b1; ovr_done = 1;
      end
      if (!chg_done && chg_at >= 0 && nbytes >= chg_at) begin
        a_t10 = 8'h99; a_t0 = 8'h99; a_tmin = 8'h99;
        a_h10 = 8'h99; a_h0 = 8'h99; a_hmin = 8'h99; a_err = ~a_err;
        chg_done = 1;
      end
    end
    start = 1'b0;
    ready = 1'b1;
    checks++;
    if (!fin || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: finished=%b left=%0d required finished=1 left=0", tag, fin, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_valid !== 1'b0 || a_data !== 8'h00 || a_busy !== 1'b0 || a_done !== 1'b0 || a_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: valid=%b data=%h busy=%b done=%b ovr=%b required 0 00 0 0 0",
               a_valid, a_data, a_busy, a_done, a_overrun);
    end
    checks++;
    if (b_valid !== 1'b0 || b_data !== 8'h00 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: valid=%b data=%h busy=%b required 0 00 0", b_valid, b_data, b_busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    int nb, no, nc;
    use_b = 0;
    a_t10 = 8'h32; a_t0 = 8'h45; a_tmin = 8'h13;
    a_h10 = 8'h46; a_h0 = 8'h81; a_hmin = 8'h70; a_err = 2'b10;
    run_frame(0, -1, -1, "basic", nb, no, nc);
    checks++;
    if (nb != 56 || nc != 57) begin
      errors++;
      $display("FAIL basic_len: bytes=%0d cycles=%0d required bytes=56 cycles=57", nb, nc);
    end
    checks++;
    if (no != 0) begin
      errors++;
      $display("FAIL basic_overrun: pulses=%0d required 0", no);
    end
  endtask

  task automatic test_leading_zero();
    int nb, no, nc;
    use_b = 0;
    a_t10 = 8'h10; a_t0 = 8'h07; a_tmin = 8'h05;
    a_h10 = 8'h00; a_h0 = 8'h53; a_hmin = 8'h09; a_err = 2'b00;
    run_frame(0, -1, -1, "lz_on", nb, no, nc);
    use_b = 1;
    b_t10 = 4'd0; b_t0 = 4'd7; b_tmin = 4'd5;
    b_h10 = 4'd0; b_h0 = 4'd0; b_hmin = 4'd0; b_err = 1'b0;
    run_frame(0, -1, -1, "lz_off", nb, no, nc);
    use_b = 0;
  endtask

  task automatic test_bad_digit_lf();
    int nb, no, nc;
    use_b = 1;
    b_t10 = 4'd12; b_t0 = 4'd15; b_tmin = 4'd9;
    b_h10 = 4'd10; b_h0 = 4'd3; b_hmin = 4'd11; b_err = 1'b1;
    run_frame(0, -1, -1, "lf_only", nb, no, nc);
    checks++;
    if (nb != 27 || nc != 28) begin
      errors++;
      $display("FAIL lf_len: bytes=%0d cycles=%0d required bytes=27 cycles=28", nb, nc);
    end
    use_b = 0;
  endtask

  task automatic test_stall();
    int nb, no, nc;
    use_b = 0;
    a_t10 = 8'h32; a_t0 = 8'h45; a_tmin = 8'h13;
    a_h10 = 8'h46; a_h0 = 8'h81; a_hmin = 8'h70; a_err = 2'b10;
    run_frame(40, -1, -1, "stall", nb, no, nc);
    checks++;
    if (nb != 56) begin
      errors++;
      $display("FAIL stall_len: bytes=%0d required 56", nb);
    end
  endtask

  task automatic test_overrun_snapshot();
    int nb, no, nc;
    use_b = 0;
    a_t10 = 8'h21; a_t0 = 8'h08; a_tmin = 8'h64;
    a_h10 = 8'h35; a_h0 = 8'h72; a_hmin = 8'h19; a_err = 2'b01;
    run_frame(0, 5, 3, "overrun", nb, no, nc);
    checks++;
    if (no != 1 || nb != 56) begin
      errors++;
      $display("FAIL overrun_pulse: pulses=%0d bytes=%0d required pulses=1 bytes=56", no, nb);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nb, no, nc, cnt;
    use_b = 0;
    ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 10; i++) begin
      @(negedge clk);
      if (a_valid === 1'b1) cnt++;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_data !== 8'h00 || cnt != 10) begin
      errors++;
      $display("FAIL reset_mid: valid=%b busy=%b data=%h seen=%0d required 0 0 00 10", a_valid, a_busy, a_data, cnt);
    end
    #1 rst = 1'b1;
    exp_q.delete();
    run_frame(0, -1, -1, "after_reset", nb, no, nc);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ready = 1'b1; use_b = 1'b0;
    a_t10 = '0; a_t0 = '0; a_tmin = '0; a_h10 = '0; a_h0 = '0; a_hmin = '0; a_err = '0;
    b_t10 = '0; b_t0 = '0; b_tmin = '0; b_h10 = '0; b_h0 = '0; b_hmin = '0; b_err = '0;
    test_reset();
    test_basic_frame();
    test_leading_zero();
    test_bad_digit_lf();
    test_stall();
    test_overrun_snapshot();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dht_uart_formatter.md
# dht_uart_formatter

Multi-sensor successor to the DHT ASCII line generator. On a start request it snapshots the BCD temperature and humidity digits of `NUM_SENS` sensors and streams one formatted ASCII line per sensor, one byte at a time, over a valid/ready byte interface to the UART transmitter. The UART TX paces the output through the handshake; there is no fixed-rate tick. The block sits between the DHT11 controllers and the UART TX FIFO.

## Interface
- `DATA_WIDTH`, 8: width of the output character.
- `NUM_SENS`, 2: number of sensors, legal range 1..4.
- `LZ_SUPPRESS`, 1: when 1, a tens digit of 0 is sent as a space (0x20).
- `EOL_CRLF`, 1: line ending. 1 sends CR LF (0x0D 0x0A). 0 sends LF only.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous, active-low.
- `i_start`  in  1  one-cycle frame request.
- `i_temp10`, `i_temp0`, `i_temp_min`  in  4*NUM_SENS each  BCD temperature digits (tens, units, tenths). Sensor k uses bits [4k+3:4k].
- `i_humi10`, `i_humi0`, `i_humi_min`  in  4*NUM_SENS each  BCD humidity digits, same packing.
- `i_error`  in  NUM_SENS  per-sensor checksum or timeout error flag.
- `o_tx_valid`  out  1  `o_tx_data` holds a character.
- `o_tx_data`  out  DATA_WIDTH  ASCII character.
- `i_tx_ready`  in  1  UART TX accepts the character.
- `o_busy`  out  1  a frame is in progress.
- `o_done`  out  1  one-cycle pulse after the last character is accepted.
- `o_overrun`  out  1  one-cycle pulse when `i_start` arrives while busy.

## Operation
- States: IDLE, SEND, DONE.
- IDLE → SEND on `i_start`. All digit inputs and `i_error` are registered into a snapshot at that same edge. Counters are cleared: `ch_idx`=0, `pos_idx`=0.
- SEND: `o_tx_valid`=1 and `o_tx_data` = char(`ch_idx`, `pos_idx`). The counters advance only on `o_tx_valid && i_tx_ready`.
  - `pos_idx` wraps to 0 at the end of a line, and `ch_idx` then increments.
  - When the last position of line `NUM_SENS-1` is accepted, go to DONE.
- DONE: `o_done`=1 for one cycle, then IDLE.
- `o_busy` = (state != IDLE).
- `i_start` in SEND or DONE is ignored: the frame is not restarted and `o_overrun` pulses for one cycle.
- Line layout, by position (L = 28 when `EOL_CRLF`=1, 27 when 0):
  - 0: '0'+ch
  - 1: space
  - 2–6: "temp:"
  - 7: space
  - 8: T10
  - 9: T0
  - 10: '.'
  - 11: Tmin
  - 12: space
  - 13–17: "humi:"
  - 18: space
  - 19: H10
  - 20: H0
  - 21: '.'
  - 22: Hmin
  - 23: TAB (0x09)
  - 24–25: "OK", or "XX" (0x58 0x58) if the snapshot error bit is set
  - 26 onward: EOL
- Digit encoding:
  - Value 0–9 → 0x30+v.
  - Value 10–15 → '?' (0x3F).
  - When `LZ_SUPPRESS`=1, a tens digit equal to 0 → 0x20.
  - Units and tenths digits are never suppressed.
- Data changing on the digit inputs during SEND does not affect the frame in flight.

## Timing
- Reset values: state=IDLE, `o_tx_valid`=0, `o_tx_data`=0x00, `o_busy`=0, `o_done`=0, `o_overrun`=0, snapshot=0, counters=0.
- `i_start` sampled high at edge N: `o_tx_valid`=1 and the first character (position 0) are visible after edge N.
- Output is registered-state driven. `o_tx_data` and `o_tx_valid` must be stable while `o_tx_valid && !i_tx_ready`.
- With `i_tx_ready` held high, one character transfers per cycle. The frame takes NUM_SENS*L transfer cycles, and `o_done` follows one cycle after the last transfer.
- Only one frame is in progress at a time. No start is queued.
- Reset asserted mid-frame: outputs return to reset values immediately. No partial line is resumed.

## Structure
- The shared package `dht_fmt_pkg` holds:
  - ASCII constants (space, '.', ':', TAB, CR, LF, 'X', '?').
  - The state enum.
  - Line-position constants and the `LINE_LEN` function of `EOL_CRLF`.
- Sub-module `dht_line_rom`: a combinational character lookup.
  - Inputs: position, channel id, 6 snapshot digits, error bit.
  - Output: ASCII character.
  - It contains the BCD-to-ASCII conversion, including leading-zero suppression.
- The top module contains the FSM, counters, snapshot registers, handshake and pulse outputs.

## Test plan
- NUM_SENS=2, sensor0 = 25.3 / 61.0 with no error, sensor1 with error, `i_tx_ready`=1 → 56 bytes: "0 temp: 25.3 humi: 61.0\tOK\r\n1 ..." with line 1 ending "\tXX\r\n". `o_done` pulses one cycle after byte 56.
- `LZ_SUPPRESS`=1, temp 07.5 → bytes 8–11 = 0x20 0x37 0x2E 0x35. With `LZ_SUPPRESS`=0 → 0x30 0x37 0x2E 0x35.
- Random `i_tx_ready` stalls → `o_tx_data` is unchanged across every stalled cycle. The byte sequence is identical to the no-stall run.
- `i_start` at byte 5, and digit inputs changed at byte 3 → `o_overrun` pulses once. The frame completes with the originally snapshotted values.
- Reset (`rst`=0) at byte 10 → `o_tx_valid`=0 and `o_busy`=0 immediately. A new `i_start` emits byte 0 = '0'.
- Digit value 12 and `EOL_CRLF`=0 → the digit is sent as '?'. The line length is 27 and ends with 0x0A only.
